// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: trivial operations (divide by zero, overflow, zero factor) skip RUN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       MDctrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             r_state, w_next;
    logic               w_accept;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_hi, r_lo, r_b_mag, r_a_mag;
    logic               r_neg_prod, r_neg_q, r_neg_r;
    logic               r_div0, r_ovf, r_mul0, r_done;
    logic [WIDTH-1:0]   r_result;

    // Operand decode on the accepting cycle
    logic               w_a_signed, w_b_signed, w_neg_a, w_neg_b, w_is_div;
    logic               w_div0, w_ovf, w_mul0, w_skip;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;

    assign w_a_signed = (MDctrl == 3'b001) || (MDctrl == 3'b010) ||
                        (MDctrl == 3'b100) || (MDctrl == 3'b110);
    assign w_b_signed = (MDctrl == 3'b001) || (MDctrl == 3'b100) || (MDctrl == 3'b110);
    assign w_neg_a    = w_a_signed && SrcA[WIDTH-1];
    assign w_neg_b    = w_b_signed && SrcB[WIDTH-1];
    assign w_a_mag    = w_neg_a ? -SrcA : SrcA;
    assign w_b_mag    = w_neg_b ? -SrcB : SrcB;
    assign w_is_div   = MDctrl[2];
    assign w_div0     = w_is_div && (SrcB == '0);
    assign w_ovf      = w_is_div && w_a_signed && w_b_signed && (SrcA == MIN_NEG) && (SrcB == '1);
    assign w_mul0     = !w_is_div && ((SrcA == '0) || (SrcB == '0));
    assign w_skip     = w_div0 || w_ovf || w_mul0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    w_next = w_skip ? S_FINISH : S_RUN;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN:    if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // One iteration step of each algorithm
    logic [WIDTH:0] w_sum, w_shift, w_diff;
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_b_mag    <= '0;
            r_a_mag    <= '0;
            r_neg_prod <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_mul0     <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_op       <= MDctrl;
            r_hi       <= '0;
            r_lo       <= w_a_mag;
            r_a_mag    <= w_a_mag;
            r_b_mag    <= w_b_mag;
            r_neg_prod <= w_neg_a ^ w_neg_b;
            r_neg_q    <= (w_neg_a ^ w_neg_b) && !w_div0;
            r_neg_r    <= w_neg_a;
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
            r_mul0     <= w_mul0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op[2]) begin
                r_hi <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    // Special results override the iterated values so both latency paths agree
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_quot, w_quot_s, w_rem, w_rem_s, w_res;

    always_comb begin
        w_prod   = r_mul0 ? '0 : {r_hi, r_lo};
        w_prod_s = r_neg_prod ? -w_prod : w_prod;
        w_quot   = r_div0 ? '1 : (r_ovf ? MIN_NEG : r_lo);
        w_quot_s = r_neg_q ? -w_quot : w_quot;
        w_rem    = r_div0 ? r_a_mag : (r_ovf ? '0 : r_hi);
        w_rem_s  = r_neg_r ? -w_rem : w_rem;
        case (r_op)
            3'b000:                 w_res = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_res = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_res = w_quot_s;
            default:                w_res = w_rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (r_state == S_FINISH) r_result <= w_res;
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = r_done;
    assign Result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit: results, latency, busy profile, ignored starts, reset.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   MDctrl = '0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         busy, done;
    logic [W-1:0] Result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MDctrl(MDctrl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           special;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Drive a request so it is accepted at the next rising edge (E0); return #1 after E0
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        MDctrl = op; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        SrcA = ~a; SrcB = ~b; MDctrl = ~op;
    endtask

    // Count edges after E0 until done; optionally pulse start (new operands) after sample inject_at
    task automatic wait_done(input int inject_at, output int lat, output int bcnt, output int overlap);
        lat = 0; bcnt = busy ? 1 : 0; overlap = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (busy && done) overlap++;
            if (lat == inject_at) begin
                start = 1'b1; MDctrl = 3'b101; SrcA = 32'h0000_1234; SrcB = 32'h0;
            end else begin
                start = 1'b0;
            end
            if (done) break;
            if (busy) bcnt++;
        end
    endtask

    vec_t vecs[$];
    int lat, bcnt, overlap;

    initial begin
        vecs.push_back('{"mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
        vecs.push_back('{"mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"mulhsu_m1_2",   3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"mulhu_2p16",    3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0});
        vecs.push_back('{"mul_zero",      3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1});
        vecs.push_back('{"div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"divu_100_7",    3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0});
        vecs.push_back('{"remu_100_7",    3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0});
        vecs.push_back('{"divu_by0",      3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"remu_by0",      3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1});
        vecs.push_back('{"div_m7_by0",    3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"rem_m7_by0",    3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1});
        vecs.push_back('{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{"div_m100_7",    3'b100, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0});

        #12;
        check("reset_busy",   {31'b0, busy}, 32'h0);
        check("reset_done",   {31'b0, done}, 32'h0);
        check("reset_result", Result, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[k]) begin
            issue(vecs[k].op, vecs[k].a, vecs[k].b);
            wait_done(-1, lat, bcnt, overlap);
            check({vecs[k].name, "_result"},  Result, vecs[k].exp);
            check({vecs[k].name, "_latency"}, W'(lat), (EARLY && vecs[k].special) ? 32'd1 : 32'd33);
            check({vecs[k].name, "_busy"},    W'(bcnt), (EARLY && vecs[k].special) ? 32'd0 : 32'd32);
            check({vecs[k].name, "_overlap"}, W'(overlap), 32'd0);
            @(posedge clk); #1;
            check({vecs[k].name, "_done_pulse"}, {31'b0, done}, 32'h0);
        end

        // Start with new operands five cycles into a DIVU is ignored
        issue(3'b101, 32'h0000_0064, 32'h0000_0007);
        wait_done(5, lat, bcnt, overlap);
        check("busy_start_result",  Result, 32'h0000_000E);
        check("busy_start_latency", W'(lat), 32'd33);

        // Start in the FINISH cycle is ignored
        issue(3'b000, 32'h0000_0003, 32'h0000_0005);
        wait_done(32, lat, bcnt, overlap);
        check("finish_start_result", Result, 32'h0000_000F);
        check("finish_start_busy_in_done", W'(overlap), 32'd0);
        @(posedge clk); #1;
        check("finish_start_not_taken", {31'b0, busy}, 32'h0);

        // Reset ten cycles into a MUL abandons it
        issue(3'b000, 32'h0000_1234, 32'h0000_0005);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy",   {31'b0, busy}, 32'h0);
        check("midrun_reset_done",   {31'b0, done}, 32'h0);
        check("midrun_reset_result", Result, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_no_done", {31'b0, done}, 32'h0);

        issue(3'b000, 32'h0000_0003, 32'h0000_0004);
        wait_done(-1, lat, bcnt, overlap);
        check("after_reset_mul_result",  Result, 32'h0000_000C);
        check("after_reset_mul_latency", W'(lat), 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
